// File: rtl/parity_pkg.sv
// Shared types and constants for the serial parity checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    DONE
  } state_t;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

  localparam int unsigned DEFAULT_DATA_W = 8;

endpackage

// File: rtl/parity_check_if.sv
// Serial-bit input / assembled-word output bundle of the parity checker.
interface parity_check_if
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

  logic              Start;
  logic              Bit_valid;
  logic              Sampled_bit;
  logic              Parity_type;
  logic [DATA_W-1:0] Data_out;
  logic              Data_valid;
  logic              Par_err;
  logic              Busy;

  modport slave (
    input  Start, Bit_valid, Sampled_bit, Parity_type,
    output Data_out, Data_valid, Par_err, Busy
  );

  modport master (
    output Start, Bit_valid, Sampled_bit, Parity_type,
    input  Data_out, Data_valid, Par_err, Busy
  );

endinterface

// File: rtl/parity_gen.sv
// Expected parity bit for a data word under even/odd parity.
module parity_gen
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic [DATA_W-1:0] data,
  input  logic              parity_type,
  output logic              parity
);

  always_comb begin
    parity = (^data) ^ (parity_type == ODD_PARITY);
  end

endmodule

// File: rtl/parity_check.sv
// Deserialises an LSB-first frame plus trailing parity bit and flags parity errors.
module parity_check
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
  input  logic           clk,
  input  logic           rst_n,
  parity_check_if.slave  bus
);

  localparam int unsigned     CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   data_q;
  logic                par_type;
  logic                par_rx;
  logic                exp_par;

  parity_gen #(.DATA_W(DATA_W)) u_gen (
    .data        (shreg),
    .parity_type (par_type),
    .parity      (exp_par)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Start restarts the frame from any state and always beats a coincident bit.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.Start) state_n = DATA;
      DATA:    if (bus.Start) state_n = DATA;
               else if (bus.Bit_valid && (cnt == LAST)) state_n = PARITY;
      PARITY:  if (bus.Start) state_n = DATA;
               else if (bus.Bit_valid) state_n = DONE;
      DONE:    state_n = bus.Start ? DATA : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.Busy       = (state == DATA) || (state == PARITY);
    bus.Data_valid = (state == DONE);
    bus.Par_err    = (state == DONE) && (par_rx != exp_par);
    bus.Data_out   = data_q;
  end

  // shreg is left untouched through DONE so the parity generator still sees the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      shreg    <= '0;
      data_q   <= '0;
      par_type <= 1'b0;
      par_rx   <= 1'b0;
    end else if (bus.Start) begin
      cnt      <= '0;
      shreg    <= '0;
      par_type <= bus.Parity_type;
    end else if (bus.Bit_valid) begin
      unique case (state)
        DATA: begin
          shreg[cnt] <= bus.Sampled_bit;
          if (cnt != LAST) cnt <= cnt + 1'b1;
        end
        PARITY: begin
          par_rx <= bus.Sampled_bit;
          data_q <= shreg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_check.sv
// Directed and randomized frames against a count-of-ones parity model.
module tb_parity_check;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [7:0] last_data = 8'h00;

  parity_check_if #(.DATA_W(8)) bus ();

  parity_check #(.DATA_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n, input logic stray);
    for (int unsigned k = 0; k < n; k++) begin
      bus.Start       = 1'b0;
      bus.Bit_valid   = stray ? 1'($urandom_range(1, 0)) : 1'b0;
      bus.Sampled_bit = 1'($urandom_range(1, 0));
      tick();
      chk("idle_dv", bus.Data_valid, 1'b0);
      chk("idle_perr", bus.Par_err, 1'b0);
      chk("idle_busy", bus.Busy, 1'b0);
      chk("idle_hold", bus.Data_out, last_data);
    end
    bus.Bit_valid = 1'b0;
  endtask

  task automatic partial(input int unsigned nbits);
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
    for (int unsigned k = 0; k < nbits; k++) begin
      bus.Bit_valid   = 1'b1;
      bus.Sampled_bit = 1'($urandom_range(1, 0));
      tick();
      chk("part_dv", bus.Data_valid, 1'b0);
      chk("part_busy", bus.Busy, 1'b1);
    end
    bus.Bit_valid = 1'b0;
  endtask

  // Ends right after the cycle showing Data_valid, so a following call is back-to-back.
  task automatic run_frame(input logic [7:0] data, input logic odd, input logic pbit,
                           input int unsigned maxgap, input logic coinc);
    logic exp_pb;
    logic exp_err;
    int unsigned gaps;
    bus.Start       = 1'b1;
    bus.Parity_type = odd;
    bus.Bit_valid   = coinc;
    bus.Sampled_bit = 1'b1;
    tick();
    bus.Start     = 1'b0;
    bus.Bit_valid = 1'b0;
    chk("start_busy", bus.Busy, 1'b1);
    chk("start_dv", bus.Data_valid, 1'b0);
    for (int i = 0; i < 9; i++) begin
      gaps = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
      for (int unsigned g = 0; g < gaps; g++) begin
        bus.Parity_type = 1'($urandom_range(1, 0));
        tick();
        chk("gap_busy", bus.Busy, 1'b1);
        chk("gap_dv", bus.Data_valid, 1'b0);
      end
      bus.Bit_valid   = 1'b1;
      bus.Sampled_bit = (i < 8) ? data[i] : pbit;
      bus.Parity_type = 1'($urandom_range(1, 0));
      tick();
      bus.Bit_valid = 1'b0;
      if (i < 8) begin
        chk("bit_busy", bus.Busy, 1'b1);
        chk("bit_dv", bus.Data_valid, 1'b0);
      end
    end
    exp_pb  = 1'(($countones(data) % 2) == 1) ^ odd;
    exp_err = (pbit != exp_pb);
    chk("done_dv", bus.Data_valid, 1'b1);
    chk("done_data", bus.Data_out, data);
    chk("done_perr", bus.Par_err, exp_err);
    chk("done_busy", bus.Busy, 1'b0);
    last_data = data;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.Start       = 1'b0;
    bus.Bit_valid   = 1'b0;
    bus.Sampled_bit = 1'b0;
    bus.Parity_type = 1'b0;
    tick();
    tick();
    chk("rst_data", bus.Data_out, 8'h00);
    chk("rst_dv", bus.Data_valid, 1'b0);
    chk("rst_perr", bus.Par_err, 1'b0);
    chk("rst_busy", bus.Busy, 1'b0);
    rst_n = 1'b1;
    idle(2, 1'b1);

    run_frame(8'hA5, 1'b0, 1'b0, 0, 1'b0);
    idle(2, 1'b0);

    run_frame(8'h07, 1'b1, 1'b1, 0, 1'b0);
    idle(1, 1'b0);

    partial(4);
    run_frame(8'h3C, 1'b0, 1'b0, 0, 1'b0);
    idle(2, 1'b0);

    partial(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", bus.Data_out, 8'h00);
    chk("arst_dv", bus.Data_valid, 1'b0);
    chk("arst_perr", bus.Par_err, 1'b0);
    chk("arst_busy", bus.Busy, 1'b0);
    last_data = 8'h00;
    tick();
    rst_n = 1'b1;
    idle(3, 1'b1);
    run_frame(8'hFF, 1'b0, 1'b0, 0, 1'b0);
    idle(1, 1'b0);

    idle(4, 1'b1);
    run_frame(8'h81, 1'b1, 1'b1, 3, 1'b0);
    idle(3, 1'b1);

    run_frame(8'h00, 1'b0, 1'b0, 0, 1'b1);
    idle(1, 1'b0);

    run_frame(8'h5A, 1'b1, 1'b0, 1, 1'b0);
    run_frame(8'hC3, 1'b0, 1'b1, 0, 1'b0);
    idle(2, 1'b0);

    for (int n = 0; n < 16; n++) begin
      logic b2b;
      b2b = 1'($urandom_range(1, 0));
      run_frame(8'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                3, 1'($urandom_range(1, 0)));
      if (!b2b) idle(1, 1'b1);
    end
    idle(2, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/parity_check.md
PARITY_CHECK -- requirements
Module: parity_check

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning number of data bits per frame.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port Start, input, 1, a one-cycle pulse marking the beginning of a new frame.
REQ-005 The block SHALL have port Bit_valid, input, 1, a strobe qualifying Sampled_bit.
REQ-006 The block SHALL have port Sampled_bit, input, 1, a serial bit, data LSB first, followed by the parity bit.
REQ-007 The block SHALL have port Parity_type, input, 1, where 0 selects even parity and 1 selects odd parity, sampled at Start.
REQ-008 The block SHALL have port Data_out, output, DATA_W, the assembled data word.
REQ-009 The block SHALL have port Data_valid, output, 1, a one-cycle pulse indicating that the frame is complete.
REQ-010 The block SHALL have port Par_err, output, 1, a one-cycle pulse coincident with Data_valid when parity mismatches.
REQ-011 The block SHALL have port Busy, output, 1, high while a frame is in progress.

Function
REQ-012 The FSM SHALL have states IDLE, DATA, PARITY and DONE.
REQ-013 From IDLE, Start SHALL move the FSM to DATA, clear the bit counter and the shift register, and latch Parity_type.
REQ-014 In DATA, each Bit_valid SHALL shift Sampled_bit into position counter of the shift register and increment the counter.
REQ-015 In DATA, Bit_valid with counter = DATA_W-1 SHALL move the FSM to PARITY.
REQ-016 In PARITY, Bit_valid SHALL capture the received parity bit and move the FSM to DONE.
REQ-017 The expected parity SHALL be the XOR of all data bits when latched type = even, and the inverse of that XOR when latched type = odd.
REQ-018 In DONE, the block SHALL register Data_out, assert Data_valid for exactly one cycle, assert Par_err in the same cycle if the received parity differs from the expected parity, and return to IDLE.
REQ-019 Latency SHALL be exactly one clock from the parity-bit Bit_valid to Data_valid.
REQ-020 Cycles without Bit_valid SHALL hold the state and the counter; there is no timeout.
REQ-021 Bit_valid in IDLE SHALL be ignored.
REQ-022 Start in DATA or PARITY SHALL abort the current frame and restart per REQ-013, with no Data_valid produced.
REQ-023 When Start and Bit_valid occur in the same cycle, Start SHALL win and the bit SHALL be discarded.
REQ-024 Start in DONE SHALL complete the DONE outputs and go to DATA (back-to-back frames).
REQ-025 Busy SHALL be high in DATA and PARITY, and low in IDLE and DONE.
REQ-026 Data_out SHALL hold its value until the next DONE.
REQ-027 Parity_type changes mid-frame SHALL have no effect.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, counter 0, shift register 0, Data_out 0, Data_valid 0, Par_err 0, Busy 0, latched type 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame with no output pulse.
REQ-030 After release, the block SHALL wait for Start.

Structure
REQ-031 Package parity_pkg SHALL hold the FSM state enum, the EVEN_PARITY=0 and ODD_PARITY=1 constants, and the default DATA_W.
REQ-032 One sub-module, parity_gen, SHALL be used: combinational, taking data word and type and producing the expected parity bit.
REQ-033 The counter SHALL be $clog2(DATA_W) bits wide, with no wrap beyond DATA_W-1.

Verification
REQ-034 Even parity, data 8'hA5, parity bit 0 -> Data_out=8'hA5, Data_valid pulse, Par_err=0.
REQ-035 Odd parity, data 8'h07, parity bit 1 -> Par_err=1 (expected 0), Data_valid pulse.
REQ-036 Start after 4 bits of a frame, then full frame 8'h3C even with parity 0 -> single Data_valid, Data_out=8'h3C, Par_err=0.
REQ-037 rst_n low after 5 bits -> all outputs 0 asynchronously, no Data_valid; next frame 8'hFF even with parity 0 is received correctly.
REQ-038 Bits gapped by 0-3 idle cycles, plus Bit_valid pulses in IDLE, with frame 8'h81 odd and parity 1 -> Data_out=8'h81, Par_err=0, stray bits ignored.
REQ-039 Start coincident with Bit_valid, then frame 8'h00 even with parity 0 -> the coincident bit is discarded, Data_out=8'h00, Par_err=0.
